// File: rtl/dcache_sweep_controller.sv
// Write-back direct-mapped L1 dcache control FSM: line fill/writeback beat sequencing plus a
// whole-cache clean+invalidate sweep. Define DCACHE_PERF_CNT_EN to add hit/miss/writeback counters.
module dcache_sweep_controller #(
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_SETS       = 64,
  localparam int BEAT_W = $clog2(WORDS_PER_LINE),
  localparam int SET_W  = $clog2(NUM_SETS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_req_valid,
  output logic              pipe_req_fulfilled,
  input  logic              flush_all_req,
  output logic              flush_all_done,
  input  logic              hit,
  input  logic              miss,
  input  logic              valid_dirty_bit,
  output logic              l2_req_valid,
  output logic              l2_req_type,
  input  logic              l2_req_fulfilled,
  output logic [BEAT_W-1:0] beat_index,
  output logic              sweep_mode,
  output logic [SET_W-1:0]  sweep_set,
  output logic              flush_mode,
  output logic              load_mode,
  output logic              set_new_l2_block_address,
  output logic              clear_selected_dirty_bit,
  output logic              clear_selected_valid_bit,
  output logic              finish_new_line_install
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       writeback_count
`endif
);

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {IDLE, FLUSH, LOAD, SW_CHECK, SW_WB, SW_NEXT} state_e;

  state_e            state, state_nxt;
  logic [BEAT_W-1:0] beat_nxt;
  logic [SET_W-1:0]  set_nxt;
  logic              flush_pending, pending_nxt;
  logic              last_beat;

  assign last_beat = (beat_index == BEAT_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      beat_index    <= '0;
      sweep_set     <= '0;
      flush_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat_index    <= beat_nxt;
      sweep_set     <= set_nxt;
      flush_pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt                = state;
    beat_nxt                 = beat_index;
    set_nxt                  = sweep_set;
    pipe_req_fulfilled       = 1'b0;
    flush_all_done           = 1'b0;
    l2_req_valid             = 1'b0;
    l2_req_type              = OP_LOAD;
    sweep_mode               = 1'b0;
    flush_mode               = 1'b0;
    load_mode                = 1'b0;
    set_new_l2_block_address = 1'b0;
    clear_selected_dirty_bit = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    // Outputs are held at zero for the whole reset assertion, not just from the next edge.
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (flush_all_req || flush_pending) begin
            state_nxt = SW_CHECK;
            set_nxt   = '0;
          end else if (pipe_req_valid) begin
            if (hit) begin
              pipe_req_fulfilled = 1'b1;
            end else if (miss) begin
              set_new_l2_block_address = 1'b1;
              beat_nxt                 = '0;
              state_nxt                = valid_dirty_bit ? FLUSH : LOAD;
            end
          end
        end
        FLUSH: begin
          flush_mode   = 1'b1;
          l2_req_valid = 1'b1;
          l2_req_type  = OP_STORE;
          if (l2_req_fulfilled) begin
            if (last_beat) begin
              set_new_l2_block_address = 1'b1;
              clear_selected_dirty_bit = 1'b1;
              clear_selected_valid_bit = 1'b1;
              beat_nxt                 = '0;
              state_nxt                = LOAD;
            end else begin
              beat_nxt = beat_index + BEAT_W'(1);
            end
          end
        end
        LOAD: begin
          load_mode    = 1'b1;
          l2_req_valid = 1'b1;
          l2_req_type  = OP_LOAD;
          if (l2_req_fulfilled) begin
            if (last_beat) begin
              finish_new_line_install  = 1'b1;
              clear_selected_dirty_bit = 1'b1;
              beat_nxt                 = '0;
              state_nxt                = IDLE;
            end else begin
              beat_nxt = beat_index + BEAT_W'(1);
            end
          end
        end
        SW_CHECK: begin
          sweep_mode = 1'b1;
          if (valid_dirty_bit) begin
            set_new_l2_block_address = 1'b1;
            beat_nxt                 = '0;
            state_nxt                = SW_WB;
          end else begin
            clear_selected_valid_bit = 1'b1;
            state_nxt                = SW_NEXT;
          end
        end
        SW_WB: begin
          sweep_mode   = 1'b1;
          flush_mode   = 1'b1;
          l2_req_valid = 1'b1;
          l2_req_type  = OP_STORE;
          if (l2_req_fulfilled) begin
            if (last_beat) begin
              clear_selected_dirty_bit = 1'b1;
              clear_selected_valid_bit = 1'b1;
              beat_nxt                 = '0;
              state_nxt                = SW_NEXT;
            end else begin
              beat_nxt = beat_index + BEAT_W'(1);
            end
          end
        end
        SW_NEXT: begin
          sweep_mode = 1'b1;
          if (sweep_set == SET_W'(NUM_SETS - 1)) begin
            flush_all_done = 1'b1;
            set_nxt        = '0;
            state_nxt      = IDLE;
          end else begin
            set_nxt   = sweep_set + SET_W'(1);
            state_nxt = SW_CHECK;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    // A request seen mid-sweep must survive the sweep's own SW_CHECK entries, so set beats clear.
    pending_nxt = flush_pending;
    if (state_nxt == SW_CHECK) pending_nxt = 1'b0;
    if (state != IDLE && flush_all_req) pending_nxt = 1'b1;
  end

`ifdef DCACHE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic hit_evt, miss_evt, wb_evt;
  assign hit_evt  = (state == IDLE) && pipe_req_fulfilled;
  assign miss_evt = (state == IDLE) && (state_nxt == LOAD || state_nxt == FLUSH);
  assign wb_evt   = (state == FLUSH || state == SW_WB) && l2_req_fulfilled && last_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count       <= '0;
      miss_count      <= '0;
      writeback_count <= '0;
    end else begin
      if (hit_evt)  hit_count       <= sat_inc(hit_count);
      if (miss_evt) miss_count      <= sat_inc(miss_count);
      if (wb_evt)   writeback_count <= sat_inc(writeback_count);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_sweep_controller.sv
// Scoreboard bench for dcache_sweep_controller (WORDS_PER_LINE=4, NUM_SETS=4): expected L2 beats
// are queued as stimulus is set up and popped as the L2 responder fulfils them.
module tb_dcache_sweep_controller;
  localparam int   WPL     = 4;
  localparam int   NS      = 4;
  localparam logic T_LOAD  = 1'b0;
  localparam logic T_STORE = 1'b1;

  logic clk = 1'b0;
  logic reset, pipe_req_valid, pipe_req_fulfilled, flush_all_req, flush_all_done;
  logic hit, miss, valid_dirty_bit, l2_req_valid, l2_req_type, l2_req_fulfilled;
  logic [1:0] beat_index, sweep_set;
  logic sweep_mode, flush_mode, load_mode, set_new_l2_block_address;
  logic clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, writeback_count;
`endif

  dcache_sweep_controller #(.WORDS_PER_LINE(WPL), .NUM_SETS(NS)) dut (
    .clk(clk), .reset(reset),
    .pipe_req_valid(pipe_req_valid), .pipe_req_fulfilled(pipe_req_fulfilled),
    .flush_all_req(flush_all_req), .flush_all_done(flush_all_done),
    .hit(hit), .miss(miss), .valid_dirty_bit(valid_dirty_bit),
    .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type),
    .l2_req_fulfilled(l2_req_fulfilled), .beat_index(beat_index),
    .sweep_mode(sweep_mode), .sweep_set(sweep_set),
    .flush_mode(flush_mode), .load_mode(load_mode),
    .set_new_l2_block_address(set_new_l2_block_address),
    .clear_selected_dirty_bit(clear_selected_dirty_bit),
    .clear_selected_valid_bit(clear_selected_valid_bit),
    .finish_new_line_install(finish_new_line_install)
`ifdef DCACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .writeback_count(writeback_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       typ;
    logic [1:0] beat;
    int         set;
    logic [3:0] flags;  // {set_new_addr, clr_dirty, clr_valid, finish_install}
    logic       cont;   // l2_req_valid must stay high after this beat
  } beat_t;

  beat_t exp_q[$];
  int    stall_q[$];
  int    vectors = 0, miscompares = 0;
  int    exp_hits = 0, exp_miss = 0, exp_wb = 0;
  logic  valid_m[NS], dirty_m[NS];
  logic  pipe_vdb = 1'b0;
  int    inj_beat = -1;
  int    done_cnt = 0;

  function automatic void push_line(logic typ, int set, logic [3:0] last_flags, logic last_cont);
    for (int b = 0; b < WPL; b++) begin
      beat_t e;
      e.typ   = typ;
      e.beat  = 2'(b);
      e.set   = set;
      e.flags = (b == WPL - 1) ? last_flags : 4'b0000;
      e.cont  = (b == WPL - 1) ? last_cont : 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  // L2 responder plus dirty/valid array model; runs until all queued beats are consumed.
  task automatic run_xfer(input int budget, input bit wait_done);
    int    cyc = 0, stall_left = 0, idx;
    bit    stall_loaded = 0, must_valid = 0, fire, clr_v_now, clr_d_now;
    beat_t e;
    done_cnt = 0;
    while (!(exp_q.size() == 0 && (!wait_done || done_cnt > 0))) begin
      if (cyc >= budget) begin
        $display("FAIL timeout: %0d beats outstanding, done pulses %0d (required 0 outstanding)",
                 exp_q.size(), done_cnt);
        vectors++; miscompares++;
        exp_q.delete();
        break;
      end
      cyc++;
      valid_dirty_bit = sweep_mode ? (valid_m[sweep_set] & dirty_m[sweep_set]) : pipe_vdb;
      flush_all_req = (inj_beat >= 0) && l2_req_valid && load_mode && (beat_index == 2'(inj_beat));
      if (flush_all_req) inj_beat = -1;
      fire = 0;
      if (l2_req_valid && exp_q.size() > 0) begin
        if (!stall_loaded) begin
          stall_left   = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
          stall_loaded = 1;
        end
        if (stall_left > 0) stall_left--;
        else begin fire = 1; stall_loaded = 0; end
      end
      l2_req_fulfilled = fire;
      #1;
      vectors++;
      if (pipe_req_fulfilled !== 1'b0) begin
        miscompares++; $display("FAIL busy_fulfilled: got %b required 0", pipe_req_fulfilled);
      end
      if (must_valid) begin
        vectors++;
        if (l2_req_valid !== 1'b1) begin
          miscompares++; $display("FAIL l2_valid_continuous: got %b required 1", l2_req_valid);
        end
      end
      if (l2_req_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL l2_unexpected: l2_req_valid got 1 required 0");
        end else if (l2_req_type !== exp_q[0].typ) begin
          miscompares++; $display("FAIL l2_type: got %b required %b", l2_req_type, exp_q[0].typ);
        end
      end
      if (fire) begin
        e = exp_q.pop_front();
        must_valid = e.cont;
        vectors++;
        if (beat_index !== e.beat) begin
          miscompares++; $display("FAIL beat_index: got %0d required %0d", beat_index, e.beat);
        end
        vectors++;
        if ({set_new_l2_block_address, clear_selected_dirty_bit, clear_selected_valid_bit,
             finish_new_line_install} !== e.flags) begin
          miscompares++;
          $display("FAIL beat_flags: got %b required %b (beat %0d)",
                   {set_new_l2_block_address, clear_selected_dirty_bit,
                    clear_selected_valid_bit, finish_new_line_install}, e.flags, e.beat);
        end
        if (e.set >= 0) begin
          vectors++;
          if (sweep_set !== 2'(e.set)) begin
            miscompares++; $display("FAIL sweep_set: got %0d required %0d", sweep_set, e.set);
          end
        end
      end
      if (flush_all_done === 1'b1) done_cnt++;
      clr_v_now = sweep_mode & clear_selected_valid_bit;
      clr_d_now = sweep_mode & clear_selected_dirty_bit;
      idx       = int'(sweep_set);
      @(posedge clk);
      if (clr_v_now) valid_m[idx] = 1'b0;
      if (clr_d_now) dirty_m[idx] = 1'b0;
      @(negedge clk);
    end
    l2_req_fulfilled = 1'b0;
    flush_all_req    = 1'b0;
  endtask

  task automatic replay_hit();
    pipe_req_valid = 1'b1; hit = 1'b1; miss = 1'b0; valid_dirty_bit = 1'b0;
    #1;
    vectors++;
    if ({l2_req_valid, pipe_req_fulfilled} !== 2'b01) begin
      miscompares++;
      $display("FAIL replay_hit: {l2_valid,fulfilled} got %b required 01", {l2_req_valid, pipe_req_fulfilled});
    end
    exp_hits++;
    @(posedge clk); @(negedge clk);
    pipe_req_valid = 1'b0; hit = 1'b0;
  endtask

  task automatic accept_miss(input logic dirty);
    pipe_req_valid = 1'b1; hit = 1'b0; miss = 1'b1; pipe_vdb = dirty; valid_dirty_bit = dirty;
    #1;
    vectors++;
    if ({set_new_l2_block_address, pipe_req_fulfilled, l2_req_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL miss_accept: {set_addr,fulfilled,l2_valid} got %b required 100",
               {set_new_l2_block_address, pipe_req_fulfilled, l2_req_valid});
    end
    exp_miss++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pipe_req_valid = 1'b1; hit = 1'b1; miss = 1'b0; flush_all_req = 1'b0;
    valid_dirty_bit = 1'b0; l2_req_fulfilled = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    vectors++;
    if ({pipe_req_fulfilled, flush_all_done, l2_req_valid, l2_req_type, beat_index, sweep_mode,
         sweep_set, flush_mode, load_mode, set_new_l2_block_address, clear_selected_dirty_bit,
         clear_selected_valid_bit, finish_new_line_install} !== 15'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required all 0",
               {pipe_req_fulfilled, flush_all_done, l2_req_valid, l2_req_type, beat_index, sweep_mode,
                sweep_set, flush_mode, load_mode, set_new_l2_block_address, clear_selected_dirty_bit,
                clear_selected_valid_bit, finish_new_line_install});
    end
`ifdef DCACHE_PERF_CNT_EN
    vectors++;
    if ({hit_count, miss_count, writeback_count} !== 96'b0) begin
      miscompares++; $display("FAIL reset_counters: got %0d/%0d/%0d required 0/0/0",
                              hit_count, miss_count, writeback_count);
    end
`endif
    @(negedge clk);
    reset = 1'b0; pipe_req_valid = 1'b0; hit = 1'b0; l2_req_fulfilled = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hit();
    for (int i = 0; i < 3; i++) replay_hit();
    pipe_req_valid = 1'b0; hit = 1'b1; l2_req_fulfilled = 1'b1;
    #1;
    vectors++;
    if (pipe_req_fulfilled !== 1'b0) begin
      miscompares++; $display("FAIL hit_without_valid: got %b required 0", pipe_req_fulfilled);
    end
    @(posedge clk); @(negedge clk);
    #1;
    vectors++;
    if ({beat_index, l2_req_valid} !== 3'b000) begin
      miscompares++; $display("FAIL idle_ignores_l2: {beat,l2_valid} got %b required 000",
                              {beat_index, l2_req_valid});
    end
    @(negedge clk);
    hit = 1'b0; l2_req_fulfilled = 1'b0;
  endtask

  task automatic test_clean_miss();
    accept_miss(1'b0);
    pipe_req_valid = 1'b0; miss = 1'b0;
    push_line(T_LOAD, -1, 4'b0101, 1'b0);
    stall_q = '{0, 2, 1, 0};
    run_xfer(60, 0);
    replay_hit();
  endtask

  task automatic test_dirty_miss();
    accept_miss(1'b1);
    pipe_req_valid = 1'b0; miss = 1'b0;
    push_line(T_STORE, -1, 4'b1110, 1'b1);
    push_line(T_LOAD,  -1, 4'b0101, 1'b0);
    exp_wb++;
    stall_q = '{1, 0, 0, 2, 0, 1, 0, 0};
    run_xfer(80, 0);
    pipe_vdb = 1'b0;
    replay_hit();
  endtask

  task automatic test_sweep();
    logic [3:0] vm, dm;
    for (int s = 0; s < NS; s++) begin
      valid_m[s] = 1'b1;
      dirty_m[s] = (s == 1 || s == 3);
      if (dirty_m[s]) begin push_line(T_STORE, s, 4'b0110, 1'b0); exp_wb++; end
    end
    stall_q = '{0, 1, 0, 0, 2, 0, 0, 1};
    flush_all_req = 1'b1;
    #1;
    vectors++;
    if (sweep_mode !== 1'b0) begin
      miscompares++; $display("FAIL sweep_start_idle: sweep_mode got %b required 0", sweep_mode);
    end
    @(posedge clk); @(negedge clk);
    flush_all_req = 1'b0;
    run_xfer(200, 1);
    for (int s = 0; s < NS; s++) begin vm[s] = valid_m[s]; dm[s] = dirty_m[s]; end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL sweep_done_pulses: got %0d required 1", done_cnt);
    end
    vectors++;
    if ({vm, dm} !== 8'h00) begin
      miscompares++; $display("FAIL sweep_arrays: valid %b dirty %b required 0000 0000", vm, dm);
    end
    #1;
    vectors++;
    if ({sweep_mode, flush_all_done, l2_req_valid} !== 3'b000) begin
      miscompares++; $display("FAIL sweep_end_idle: got %b required 000",
                              {sweep_mode, flush_all_done, l2_req_valid});
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_flush_during_load();
    for (int s = 0; s < NS; s++) begin valid_m[s] = 1'b1; dirty_m[s] = (s == 0); end
    accept_miss(1'b0);
    hit = 1'b1; miss = 1'b0;
    push_line(T_LOAD,  -1, 4'b0101, 1'b0);
    push_line(T_STORE,  0, 4'b0110, 1'b0);
    exp_wb++;
    inj_beat = 1;
    run_xfer(200, 1);
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL pending_done_pulses: got %0d required 1", done_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if ({pipe_req_fulfilled, flush_all_done, sweep_mode} !== 3'b100) begin
        miscompares++; $display("FAIL hit_after_sweep: {fulfilled,done,sweep} got %b required 100",
                                {pipe_req_fulfilled, flush_all_done, sweep_mode});
      end
      exp_hits++;
      @(posedge clk); @(negedge clk);
    end
    pipe_req_valid = 1'b0; hit = 1'b0;
  endtask

`ifdef DCACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    vectors++;
    if (hit_count !== 32'(exp_hits)) begin
      miscompares++; $display("FAIL hit_count: got %0d required %0d", hit_count, exp_hits);
    end
    vectors++;
    if (miss_count !== 32'(exp_miss)) begin
      miscompares++; $display("FAIL miss_count: got %0d required %0d", miss_count, exp_miss);
    end
    vectors++;
    if (writeback_count !== 32'(exp_wb)) begin
      miscompares++; $display("FAIL writeback_count: got %0d required %0d", writeback_count, exp_wb);
    end
  endtask
`endif

  task automatic test_reset_mid_flush();
    accept_miss(1'b1);
    pipe_req_valid = 1'b0; miss = 1'b0;
    push_line(T_STORE, -1, 4'b1110, 1'b1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    run_xfer(40, 0);
    #1;
    vectors++;
    if ({l2_req_valid, l2_req_type, beat_index} !== 4'b1110) begin
      miscompares++; $display("FAIL pre_reset_flush: {valid,type,beat} got %b required 1110",
                              {l2_req_valid, l2_req_type, beat_index});
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({l2_req_valid, flush_mode, beat_index} !== 4'b0000) begin
      miscompares++; $display("FAIL async_reset: {valid,flush_mode,beat} got %b required 0000",
                              {l2_req_valid, flush_mode, beat_index});
    end
`ifdef DCACHE_PERF_CNT_EN
    vectors++;
    if ({hit_count, miss_count, writeback_count} !== 96'b0) begin
      miscompares++; $display("FAIL reset_counters_mid: got %0d/%0d/%0d required 0/0/0",
                              hit_count, miss_count, writeback_count);
    end
`endif
    @(negedge clk);
    reset = 1'b0; pipe_vdb = 1'b0; valid_dirty_bit = 1'b0;
    #1;
    vectors++;
    if ({l2_req_valid, flush_mode, load_mode} !== 3'b000) begin
      miscompares++; $display("FAIL post_reset_idle: got %b required 000",
                              {l2_req_valid, flush_mode, load_mode});
    end
    @(posedge clk); @(negedge clk);
    replay_hit();
  endtask

  initial begin
    reset = 1'b1; pipe_req_valid = 1'b0; flush_all_req = 1'b0; hit = 1'b0; miss = 1'b0;
    valid_dirty_bit = 1'b0; l2_req_fulfilled = 1'b0;
    test_reset();
    test_hit();
    test_clean_miss();
    test_dirty_miss();
    test_sweep();
    test_flush_during_load();
`ifdef DCACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_sweep_controller.md
Name: dcache_sweep_controller

Overview:
Next-generation write-back, direct-mapped L1 data-cache control FSM. It sits between the pipeline, the dcache datapath (tag/valid/dirty arrays, line buffer) and the L2 port. Relative to the current controller it:
- owns the line beat counter internally, parametrised by words per line;
- qualifies pipeline requests with a valid;
- adds a whole-cache clean-and-invalidate sweep (flush-all) that walks every set and writes back dirty lines.

Parameters:
WORDS_PER_LINE, 4, 32-bit words per cache line (power of 2, >=2); BEAT_W = $clog2(WORDS_PER_LINE)
NUM_SETS, 64, number of sets (power of 2, >=2); SET_W = $clog2(NUM_SETS)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
pipe_req_valid  input  1  pipeline access presented this cycle
pipe_req_fulfilled  output  1  access completes this cycle
flush_all_req  input  1  request clean+invalidate of whole cache (pulse or level)
flush_all_done  output  1  one-cycle pulse when sweep completes
hit  input  1  selected line valid and tag match
miss  input  1  selected line not hit
valid_dirty_bit  input  1  selected line valid and dirty
l2_req_valid  output  1  L2 request outstanding
l2_req_type  output  memory_operation_e  LOAD or STORE
l2_req_fulfilled  input  1  one word beat accepted or returned by L2
beat_index  output  BEAT_W  word offset of the current L2 beat
sweep_mode  output  1  datapath indexes arrays with sweep_set instead of pipeline address
sweep_set  output  SET_W  set under sweep
flush_mode  output  1  datapath sources line-buffer words to L2
load_mode  output  1  datapath writes L2 words into the line
set_new_l2_block_address  output  1  latch L2 block address (victim for flush, requested for load)
clear_selected_dirty_bit  output  1  clear dirty bit of selected line
clear_selected_valid_bit  output  1  clear valid bit of selected line
finish_new_line_install  output  1  write tag, set valid for the loaded line

Behaviour:
States: IDLE, FLUSH, LOAD, SW_CHECK, SW_WB, SW_NEXT.

Reset:
- Asynchronous; forces state IDLE, beat_index 0, sweep_set 0, flush_pending 0.
- All outputs 0; l2_req_type LOAD.
- Reset mid-transaction drops l2_req_valid immediately. No partial-line cleanup is performed.

flush_pending:
- Set when flush_all_req=1 in any state other than IDLE.
- Cleared on entry to SW_CHECK.

IDLE:
- flush_all_req|flush_pending -> SW_CHECK with sweep_set=0. Takes priority over a simultaneous pipeline request; pipe_req_fulfilled=0 in that cycle.
- Otherwise pipe_req_valid&hit -> pipe_req_fulfilled=1 (combinational), stay in IDLE.
- pipe_req_valid&miss&!valid_dirty_bit -> LOAD.
- pipe_req_valid&miss&valid_dirty_bit -> FLUSH.
- On entry to LOAD or FLUSH: set_new_l2_block_address=1 and beat_index<=0.

FLUSH:
- Moore outputs: flush_mode=1, l2_req_valid=1, l2_req_type=STORE.
- Each l2_req_fulfilled increments beat_index.
- Fulfilled on beat WORDS_PER_LINE-1: assert set_new_l2_block_address, clear_selected_dirty_bit and clear_selected_valid_bit; beat_index<=0; -> LOAD.

LOAD:
- Moore outputs: load_mode=1, l2_req_valid=1, l2_req_type=LOAD; beat counting as in FLUSH.
- Last beat: assert finish_new_line_install and clear_selected_dirty_bit; -> IDLE.
- The replayed access then hits. pipe_req_fulfilled is never asserted in LOAD or FLUSH.

SW_CHECK (sweep_mode=1, one cycle):
- valid_dirty_bit=1: set_new_l2_block_address=1, beat_index<=0, -> SW_WB.
- Otherwise: clear_selected_valid_bit=1, -> SW_NEXT.

SW_WB:
- As FLUSH, but with sweep_mode=1.
- Last beat: clear dirty and valid bits, -> SW_NEXT.

SW_NEXT:
- sweep_set==NUM_SETS-1: flush_all_done=1, sweep_set<=0, -> IDLE.
- Otherwise: sweep_set+1, -> SW_CHECK.

Handshake and boundary rules:
- l2_req_valid and l2_req_type are stable until the last beat is fulfilled.
- l2_req_fulfilled outside FLUSH/LOAD/SW_WB is ignored.
- beat_index wraps only through the explicit load to 0, never by overflow.
- flush_all_req arriving during the sweep itself re-arms flush_pending, so exactly one further sweep follows.

Optional Feature:
Macro DCACHE_PERF_CNT_EN.

When defined:
- Adds outputs hit_count, miss_count and writeback_count, each 32 bits.
- hit_count increments on every pipe_req_fulfilled cycle in IDLE.
- miss_count increments on every IDLE->LOAD/FLUSH transition.
- writeback_count increments on every completed FLUSH or SW_WB line.
- All three saturate at 0xFFFFFFFF and are cleared by reset.

When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- WORDS_PER_LINE=4: pipe_req_valid=1, hit=1 -> pipe_req_fulfilled=1 the same cycle, l2_req_valid=0, state IDLE.
- Clean miss, L2 fulfills beats with 0/2/1/0 stall cycles -> LOAD; beat_index 0,1,2,3; finish_new_line_install pulses once with beat 3; back to IDLE.
- Dirty miss -> 4 STORE beats, then set_new_l2_block_address + clear dirty/valid, 4 LOAD beats, install; l2_req_valid high continuously for 8 beats plus stalls.
- NUM_SETS=4, sets 1 and 3 dirty, flush_all_req pulse -> 8 STORE beats total (sweep_set 1 and 3); valid cleared on all 4 sets; flush_all_done single pulse; IDLE.
- flush_all_req pulse during LOAD beat 1 -> load completes normally; next cycle enters SW_CHECK; a simultaneous pipe hit is not fulfilled until after flush_all_done.
- Assert reset mid-FLUSH at beat 2 -> l2_req_valid=0 immediately, beat_index=0, IDLE after release; DCACHE_PERF_CNT_EN counters read 0.
